// File: rtl/amns_pkg.sv
// Shared types and default sizing for the AMNS modular-multiplication sequencer.
package amns_pkg;

    localparam int unsigned WORD_WIDTH_DEF = 17;
    localparam int unsigned N_DEF          = 5;
    localparam int unsigned S_DEF          = 4;
    localparam int unsigned I_W_DEF        = $clog2(N_DEF);
    localparam int unsigned W_W_DEF        = $clog2(S_DEF);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MULT,
        ST_RED,
        ST_LATCH,
        ST_STORE,
        ST_DONE
    } state_e;

    // Counter width that stays at least one bit for degenerate sizes.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/amns_loop_counter.sv
// Nested coefficient (i) / word (w) counter; exposes its next value so the
// owner can register outputs that line up with the counter itself.
module amns_loop_counter
    import amns_pkg::*;
#(
    parameter int unsigned N  = N_DEF,
    parameter int unsigned S  = S_DEF,
    parameter int unsigned IW = cnt_w(N),
    parameter int unsigned WW = cnt_w(S)
) (
    input  logic          clock_i,
    input  logic          reset_i,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [IW-1:0] i_next_c_o,
    output logic [WW-1:0] w_next_c_o,
    output logic          w_last_c_o,
    output logic          last_c_o
);

    logic [IW-1:0] i_q, i_d;
    logic [WW-1:0] w_q, w_d;

    assign w_last_c_o = (w_q == WW'(S - 1));
    assign last_c_o   = w_last_c_o && (i_q == IW'(N - 1));
    assign i_next_c_o = i_d;
    assign w_next_c_o = w_d;

    // Clear wins over enable so a phase hand-off restarts at (0,0).
    always_comb begin
        i_d = i_q;
        w_d = w_q;
        if (clr_i) begin
            i_d = '0;
            w_d = '0;
        end else if (en_i) begin
            if (w_last_c_o) begin
                w_d = '0;
                i_d = (i_q == IW'(N - 1)) ? '0 : i_q + IW'(1);
            end else begin
                w_d = w_q + WW'(1);
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            i_q <= '0;
            w_q <= '0;
        end else begin
            i_q <= i_d;
            w_q <= w_d;
        end
    end

endmodule

// File: rtl/amns_mm_sequencer.sv
// Control sequencer for one AMNS Montgomery multiplication: load, multiply,
// reduce, latch, store. Every output is registered from next-state values.
module amns_mm_sequencer
    import amns_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = WORD_WIDTH_DEF,
    parameter int unsigned N          = N_DEF,
    parameter int unsigned S          = S_DEF
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic         load_done_i,
    input  logic         store_done_i,
    output logic         load_start_o,
    output logic         store_start_o,
    output logic         A_reg_rot_o,
    output logic         B_reg_shift_o,
    output logic         M_reg_rot_o,
    output logic         M_p_0_reg_rot_o,
    output logic         RES_reg_en_o,
    output logic         acc_clear_o,
    output logic [N-1:0] lambda_mask_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int unsigned IW = cnt_w(N);
    localparam int unsigned WW = cnt_w(S);

    if ((WORD_WIDTH < 2) || ((N == N_DEF) && (IW != I_W_DEF)) ||
        ((S == S_DEF) && (WW != W_W_DEF))) begin : g_param_chk
        $error("amns_mm_sequencer: inconsistent sizing parameters");
    end

    state_e        state_q, state_d;
    logic          cnt_clr, cnt_en, w_last, last;
    logic [IW-1:0] i_next;
    logic [WW-1:0] w_next;
    logic          w_next_last;

    logic          load_start_d, store_start_d, a_rot_d, b_shift_d;
    logic          m_rot_d, mp0_rot_d, res_en_d, acc_clear_d, busy_d, done_d;
    logic [N-1:0]  lambda_d;

    amns_loop_counter #(.N(N), .S(S), .IW(IW), .WW(WW)) u_cnt (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clr_i      (cnt_clr),
        .en_i       (cnt_en),
        .i_next_c_o (i_next),
        .w_next_c_o (w_next),
        .w_last_c_o (w_last),
        .last_c_o   (last)
    );

    assign w_next_last = (w_next == WW'(S - 1));

    always_comb begin
        state_d       = state_q;
        cnt_clr       = 1'b0;
        cnt_en        = 1'b0;
        load_start_d  = 1'b0;
        store_start_d = 1'b0;
        a_rot_d       = 1'b0;
        b_shift_d     = 1'b0;
        m_rot_d       = 1'b0;
        mp0_rot_d     = 1'b0;
        res_en_d      = 1'b0;
        acc_clear_d   = 1'b0;
        busy_d        = 1'b0;
        done_d        = 1'b0;
        lambda_d      = '0;

        unique case (state_q)
            ST_IDLE:  if (start_i) state_d = ST_LOAD;
            ST_LOAD:  if (load_done_i) begin
                          state_d = ST_MULT;
                          cnt_clr = 1'b1;
                      end
            ST_MULT:  begin
                          cnt_en = 1'b1;
                          if (last) begin
                              state_d = ST_RED;
                              cnt_clr = 1'b1;
                          end
                      end
            ST_RED:   begin
                          cnt_en = 1'b1;
                          if (last) state_d = ST_LATCH;
                      end
            ST_LATCH: state_d = ST_STORE;
            ST_STORE: if (store_done_i) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        // Outputs describe the cycle about to begin, hence keyed on state_d.
        load_start_d  = (state_q == ST_IDLE) && (state_d == ST_LOAD);
        acc_clear_d   = load_start_d;
        store_start_d = (state_q == ST_LATCH);
        busy_d        = (state_d != ST_IDLE);
        res_en_d      = (state_d == ST_LATCH);
        done_d        = (state_d == ST_DONE);
        if (state_d == ST_MULT) begin
            a_rot_d   = w_next_last;
            b_shift_d = !w_next_last;
            for (int unsigned k = 0; k < N; k++) begin
                lambda_d[k] = (32'(i_next) > k);
            end
        end
        if (state_d == ST_RED) begin
            m_rot_d   = 1'b1;
            mp0_rot_d = w_next_last;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q         <= ST_IDLE;
            load_start_o    <= 1'b0;
            store_start_o   <= 1'b0;
            A_reg_rot_o     <= 1'b0;
            B_reg_shift_o   <= 1'b0;
            M_reg_rot_o     <= 1'b0;
            M_p_0_reg_rot_o <= 1'b0;
            RES_reg_en_o    <= 1'b0;
            acc_clear_o     <= 1'b0;
            lambda_mask_o   <= '0;
            busy_o          <= 1'b0;
            done_o          <= 1'b0;
        end else begin
            state_q         <= state_d;
            load_start_o    <= load_start_d;
            store_start_o   <= store_start_d;
            A_reg_rot_o     <= a_rot_d;
            B_reg_shift_o   <= b_shift_d;
            M_reg_rot_o     <= m_rot_d;
            M_p_0_reg_rot_o <= mp0_rot_d;
            RES_reg_en_o    <= res_en_d;
            acc_clear_o     <= acc_clear_d;
            lambda_mask_o   <= lambda_d;
            busy_o          <= busy_d;
            done_o          <= done_d;
        end
    end

    logic unused_w_last;
    assign unused_w_last = w_last;

endmodule

// File: tb/tb_amns_mm_sequencer.sv
// Randomized directed bench for amns_mm_sequencer against a phase/index model.
module tb_amns_mm_sequencer;

    localparam int NN = 5;
    localparam int SS = 4;
    localparam int OW = 10 + NN;

    logic clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    logic          reset_i = 1'b1, start_i = 1'b0, load_done_i = 1'b0, store_done_i = 1'b0;
    logic          load_start_o, store_start_o, A_reg_rot_o, B_reg_shift_o;
    logic          M_reg_rot_o, M_p_0_reg_rot_o, RES_reg_en_o, acc_clear_o, busy_o, done_o;
    logic [NN-1:0] lambda_mask_o;

    amns_mm_sequencer #(.WORD_WIDTH(17), .N(NN), .S(SS)) dut (
        .clock_i        (clock_i),
        .reset_i        (reset_i),
        .start_i        (start_i),
        .load_done_i    (load_done_i),
        .store_done_i   (store_done_i),
        .load_start_o   (load_start_o),
        .store_start_o  (store_start_o),
        .A_reg_rot_o    (A_reg_rot_o),
        .B_reg_shift_o  (B_reg_shift_o),
        .M_reg_rot_o    (M_reg_rot_o),
        .M_p_0_reg_rot_o(M_p_0_reg_rot_o),
        .RES_reg_en_o   (RES_reg_en_o),
        .acc_clear_o    (acc_clear_o),
        .lambda_mask_o  (lambda_mask_o),
        .busy_o         (busy_o),
        .done_o         (done_o)
    );

    typedef enum int {P_IDLE, P_LOAD, P_MULT, P_RED, P_LATCH, P_STORE, P_DONE} phase_t;

    int     total = 0, passes = 0, fails = 0, cyc = 0;
    phase_t m_phase = P_IDLE;
    int     m_idx = 0;
    bit     m_first = 1'b0;
    int     n_ls, n_ss, n_a, n_b, n_m, n_mp, n_res, n_done, n_acc;
    int     ld_cyc, sd_cyc, res_cyc, done_cyc;
    logic [NN-1:0] lam_seen [NN];
    logic [NN-1:0] lam_req  [NN];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Spec-level model: which phase we are in and how far into it.
    task automatic model_update(input bit st, input bit ld, input bit sd, input bit rst);
        m_first = 1'b0;
        if (rst) begin
            m_phase = P_IDLE;
            m_idx   = 0;
        end else begin
            case (m_phase)
                P_IDLE:  if (st) begin m_phase = P_LOAD; m_first = 1'b1; end
                P_LOAD:  if (ld) begin m_phase = P_MULT; m_idx = 0; end
                P_MULT:  begin
                             m_idx++;
                             if (m_idx == NN * SS) begin m_phase = P_RED; m_idx = 0; end
                         end
                P_RED:   begin
                             m_idx++;
                             if (m_idx == NN * SS) m_phase = P_LATCH;
                         end
                P_LATCH: begin m_phase = P_STORE; m_first = 1'b1; end
                P_STORE: if (sd) m_phase = P_DONE;
                default: m_phase = P_IDLE;
            endcase
        end
    endtask

    function automatic logic [OW-1:0] model_out();
        bit ls, ss, a, b, m, mp, res, acc, busy, dn;
        logic [NN-1:0] lam;
        ls   = (m_phase == P_LOAD) && m_first;
        acc  = ls;
        ss   = (m_phase == P_STORE) && m_first;
        busy = (m_phase != P_IDLE);
        a    = (m_phase == P_MULT) && (m_idx % SS == SS - 1);
        b    = (m_phase == P_MULT) && (m_idx % SS != SS - 1);
        lam  = (m_phase == P_MULT) ? NN'((1 << (m_idx / SS)) - 1) : '0;
        m    = (m_phase == P_RED);
        mp   = (m_phase == P_RED) && (m_idx % SS == SS - 1);
        res  = (m_phase == P_LATCH);
        dn   = (m_phase == P_DONE);
        return {ls, ss, a, b, m, mp, res, acc, busy, dn, lam};
    endfunction

    task automatic cycle(input bit st, input bit ld, input bit sd, input bit rst);
        phase_t pre;
        logic [OW-1:0] obs;
        cyc++;
        start_i = st; load_done_i = ld; store_done_i = sd; reset_i = rst;
        pre = m_phase;
        @(posedge clock_i);
        model_update(st, ld, sd, rst);
        #1;
        obs = {load_start_o, store_start_o, A_reg_rot_o, B_reg_shift_o, M_reg_rot_o,
               M_p_0_reg_rot_o, RES_reg_en_o, acc_clear_o, busy_o, done_o, lambda_mask_o};
        check($sformatf("outputs@%0d", cyc), 64'(obs), 64'(model_out()));
        if (ld && pre == P_LOAD && !rst) ld_cyc = cyc;
        if (sd && pre == P_STORE && !rst) sd_cyc = cyc;
        if (A_reg_rot_o) begin
            if (n_a < NN) lam_seen[n_a] = lambda_mask_o;
            n_a++;
        end
        if (load_start_o)    n_ls++;
        if (acc_clear_o)     n_acc++;
        if (store_start_o)   n_ss++;
        if (B_reg_shift_o)   n_b++;
        if (M_reg_rot_o)     n_m++;
        if (M_p_0_reg_rot_o) n_mp++;
        if (RES_reg_en_o)    begin n_res++; res_cyc = cyc + 1; end
        if (done_o)          begin n_done++; done_cyc = cyc + 1; end
    endtask

    task automatic clear_counts();
        n_ls = 0; n_ss = 0; n_a = 0; n_b = 0; n_m = 0; n_mp = 0; n_res = 0; n_done = 0; n_acc = 0;
        ld_cyc = -1000; sd_cyc = -1000; res_cyc = -1; done_cyc = -1;
        for (int k = 0; k < NN; k++) lam_seen[k] = 'x;
    endtask

    task automatic run_op(input int ld_delay, input int sd_delay, input bit hold, input bit spur);
        int guard;
        clear_counts();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        repeat (ld_delay) cycle(hold, 1'b0, 1'b0, 1'b0);
        cycle(hold, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_phase != P_STORE && guard < 200) begin
            cycle(hold, spur && $urandom_range(0, 1) == 1, spur && $urandom_range(0, 1) == 1, 1'b0);
            guard++;
        end
        check("reach_store", 64'(guard < 200), 64'(1));
        repeat (sd_delay) cycle(hold, 1'b0, 1'b0, 1'b0);
        cycle(hold, 1'b0, 1'b1, 1'b0);
        cycle(hold, 1'b0, 1'b0, 1'b0);
        check("n_load_start", 64'(n_ls), 64'(1));
        check("n_acc_clear", 64'(n_acc), 64'(1));
        check("n_b_shift", 64'(n_b), 64'(15));
        check("n_a_rot", 64'(n_a), 64'(5));
        check("n_m_rot", 64'(n_m), 64'(20));
        check("n_mp0_rot", 64'(n_mp), 64'(5));
        check("n_res_en", 64'(n_res), 64'(1));
        check("n_store_start", 64'(n_ss), 64'(1));
        check("n_done", 64'(n_done), 64'(1));
        check("ld_to_res_latency", 64'(res_cyc - ld_cyc), 64'(41));
        check("sd_to_done_latency", 64'(done_cyc - sd_cyc), 64'(1));
        for (int k = 0; k < NN; k++) check($sformatf("lambda_i%0d", k), 64'(lam_seen[k]), 64'(lam_req[k]));
    endtask

    initial begin : stim
        int guard;
        lam_req[0] = 5'b00000; lam_req[1] = 5'b00001; lam_req[2] = 5'b00011;
        lam_req[3] = 5'b00111; lam_req[4] = 5'b01111;
        clear_counts();

        // reset state
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b1, 1'b1, 1'b1);
        check("reset_busy", 64'(busy_o), 64'(0));
        cycle(1'b0, 1'b1, 1'b1, 1'b0);

        // basic run, load_done 3 cycles after start
        run_op(3, 2, 1'b0, 1'b0);

        // reset in cycle 10 of MULT
        clear_counts();
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (!(m_phase == P_MULT && m_idx == 9) && guard < 50) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0);
            guard++;
        end
        check("reach_mult10", 64'(guard < 50), 64'(1));
        cycle(1'b0, 1'b0, 1'b0, 1'b1);
        check("midreset_outputs", 64'({busy_o, B_reg_shift_o, A_reg_rot_o, lambda_mask_o}), 64'(0));
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        run_op(0, 0, 1'b0, 1'b0);

        // start held high with spurious done pulses; back-to-back ops
        run_op(1, 1, 1'b1, 1'b1);
        run_op(2, 0, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // randomized operations
        for (int t = 0; t < 4; t++) begin
            run_op(int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
                   $urandom_range(0, 1) == 1, 1'b1);
            repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
